// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_unit
//  Description : RV32I fetch stage. Owns the PC, issues instruction memory
//                reads, buffers responses in a slot+skid queue and handles
//                execute-stage redirects, including dropping in-flight words.
//  Revision    : 1.0  initial release
// ============================================================================
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h4000_0060
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_address,
    output logic        imem_read,
    input  logic [31:0] imem_rdata,
    input  logic        imem_resp,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        if_ready,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr
);

    localparam logic [31:0] c_PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FETCH   = 2'd1,
        S_HOLD    = 2'd2,
        S_DISCARD = 2'd3
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_target;
    logic        r_slot_v;
    logic [31:0] r_slot_pc;
    logic [31:0] r_slot_instr;
    logic        r_skid_v;
    logic [31:0] r_skid_pc;
    logic [31:0] r_skid_instr;

    logic        w_consume;
    logic        w_slot_free;
    logic [31:0] w_pc_inc;

    assign w_consume    = r_slot_v & if_ready;
    assign w_slot_free  = ~r_slot_v | w_consume;
    assign w_pc_inc     = r_pc + c_PC_STEP;

    assign imem_read    = (r_state == S_FETCH) || (r_state == S_DISCARD);
    assign imem_address = r_pc;

    assign if_valid     = r_slot_v;
    assign if_pc        = r_slot_pc;
    assign if_instr     = r_slot_instr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_pc         <= RESET_PC;
            r_target     <= 32'h0;
            r_slot_v     <= 1'b0;
            r_slot_pc    <= 32'h0;
            r_slot_instr <= 32'h0;
            r_skid_v     <= 1'b0;
            r_skid_pc    <= 32'h0;
            r_skid_instr <= 32'h0;
        end else begin
            // A consumed slot empties unless a later branch refills it.
            if (w_consume) begin
                r_slot_v <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    r_state <= S_FETCH;
                end

                S_FETCH: begin
                    if (redirect_valid) begin
                        r_slot_v <= 1'b0;
                        r_skid_v <= 1'b0;
                        if (imem_resp) begin
                            r_pc <= redirect_pc;
                        end else begin
                            r_target <= redirect_pc;
                            r_state  <= S_DISCARD;
                        end
                    end else if (imem_resp) begin
                        r_pc <= w_pc_inc;
                        if (w_slot_free) begin
                            r_slot_v     <= 1'b1;
                            r_slot_pc    <= r_pc;
                            r_slot_instr <= imem_rdata;
                        end else begin
                            r_skid_v     <= 1'b1;
                            r_skid_pc    <= r_pc;
                            r_skid_instr <= imem_rdata;
                            r_state      <= S_HOLD;
                        end
                    end
                end

                S_HOLD: begin
                    if (redirect_valid) begin
                        r_slot_v <= 1'b0;
                        r_skid_v <= 1'b0;
                        r_pc     <= redirect_pc;
                        r_state  <= S_FETCH;
                    end else if (w_consume) begin
                        r_slot_v     <= r_skid_v;
                        r_slot_pc    <= r_skid_pc;
                        r_slot_instr <= r_skid_instr;
                        r_skid_v     <= 1'b0;
                        r_state      <= S_FETCH;
                    end
                end

                S_DISCARD: begin
                    // The outstanding word belongs to the abandoned path.
                    if (redirect_valid) begin
                        r_slot_v <= 1'b0;
                        r_skid_v <= 1'b0;
                    end
                    if (imem_resp) begin
                        r_pc    <= redirect_valid ? redirect_pc : r_target;
                        r_state <= S_FETCH;
                    end else if (redirect_valid) begin
                        r_target <= redirect_pc;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage of the pipelined RV32I core. It owns the program counter and drives read requests to the instruction memory/cache port. It buffers returned instruction words in a two-entry queue (output slot plus skid) and presents them to the IF/ID pipeline register with a valid/ready handshake. It also handles control-flow redirects from the execute stage, including discarding a response that was already in flight when the redirect arrived.

## Interface
- RESET_PC, 32'h4000_0060, PC of the first fetch after reset
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-low; state clears immediately while rst=0
- imem_address  out  32  word address of the current request; stable while imem_read=1 and no imem_resp
- imem_read  out  1  read request; held until imem_resp
- imem_rdata  in  32  instruction word, valid when imem_resp=1
- imem_resp  in  1  single-cycle response pulse; may occur in the first cycle imem_read=1
- redirect_valid  in  1  one-cycle redirect request (taken branch/jump)
- redirect_pc  in  32  redirect target, word aligned
- if_ready  in  1  IF/ID register accepts this cycle (load enable of that register)
- if_valid  out  1  output slot holds an instruction
- if_pc  out  32  PC of the slot instruction
- if_instr  out  32  slot instruction word

## Operation
- State: pc_q (next fetch PC), target_q, slot {v,pc,instr}, skid {v,pc,instr}, FSM in {IDLE, FETCH, HOLD, DISCARD}.
- Reset values: state=IDLE, pc_q=RESET_PC, target_q=0, slot and skid valid=0 with pc/instr=0. Outputs during and right after reset: imem_read=0, imem_address=RESET_PC, if_valid=0, if_pc=0, if_instr=0.
- Consume: the slot is consumed when if_valid & if_ready.
- imem_read=1 only in FETCH and DISCARD. imem_address=pc_q in both states.
- IDLE: go to FETCH on the first edge after rst deasserts.
- FETCH, imem_resp=1, no redirect:
  - Write {pc_q, imem_rdata} into the slot if the slot is empty or consumed this cycle, otherwise into the skid.
  - pc_q <= pc_q+4, mod 2^32; 32'hFFFF_FFFC wraps to 0.
  - If the skid becomes full, go to HOLD; otherwise stay in FETCH and issue the next request in the following cycle.
- HOLD: no request. When the slot is consumed, skid moves to slot, skid clears, and the FSM goes to FETCH.
- Redirect (highest priority, any state except IDLE):
  - Slot and skid valid clear at the edge. A consume in the same cycle still counts for the downstream register.
  - FETCH with imem_resp=1 in the same cycle: drop the response, pc_q <= redirect_pc, stay in FETCH.
  - FETCH with no imem_resp: target_q <= redirect_pc, go to DISCARD. pc_q is unchanged so the outstanding address stays stable.
  - HOLD: pc_q <= redirect_pc, go to FETCH.
  - DISCARD: target_q <= redirect_pc (last redirect wins), stay in DISCARD.
- DISCARD: keep imem_read=1 at the old address. On imem_resp, drop the data, set pc_q <= target_q, and go to FETCH. If imem_resp and redirect_valid arrive together, pc_q <= redirect_pc.
- The skid is never written while it is full, because HOLD issues no request.
- Async reset mid-request: imem_read drops immediately and the in-flight response is ignored. The memory side must tolerate an abandoned request on reset.

## Timing
- Fetch latency: instruction visible on if_valid/if_pc/if_instr the cycle after imem_resp.
- Throughput: 1 instruction/cycle with imem_resp every cycle and if_ready=1.
- First request: imem_read=1 in the second cycle after rst rises (one IDLE cycle).
- Redirect penalty:
  - Same-cycle-resp case: request to redirect_pc the next cycle.
  - DISCARD case: request to redirect_pc the cycle after the dropped response.
- All outputs are registered except imem_read and imem_address, which are decoded from the FSM state and pc_q.

## Test plan
- Reset then a 1-cycle memory that responds every cycle, with if_ready=1 → addresses 0x40000060, 0x64, 0x68… on consecutive cycles. Each if_pc appears one cycle after its response with the matching instruction word.
- if_ready=0 for 5 cycles starting when slot 0x60 is valid → 0x64 goes to the skid and the FSM enters HOLD with imem_read=0. When if_ready=1, 0x60 is consumed, then 0x64, and fetching resumes at 0x68 with no instruction lost or duplicated.
- Redirect to 0x40000100 while a request to 0x70 is outstanding (response 3 cycles later) → imem_address stays 0x70 until the response. That word is dropped, if_valid stays 0, and the next request is 0x40000100.
- Redirect to 0x200 in the same cycle as the response for 0x80 → 0x80 is never presented, the slot and skid are flushed, and the next imem_address is 0x200.
- Two redirects (0x300 then 0x400) during DISCARD → the first fetch after the dropped response is 0x400.
- pc_q=0xFFFFFFFC on a response, then rst pulsed low mid-request → the next fetch address is 0x00000000. After the reset pulse, imem_read goes low immediately, all outputs return to their reset values, and the next fetch is RESET_PC.
